ysyx_22040759_mem_arbiter: RTL and testbench

- N-channel arbiter that merges CPU-side memory requesters onto one downstream memory port (AXI bridge side). Typical requesters: icache, dcache, future uncached/MMIO paths.
- Each upstream channel uses the same valid/ready/req/addr/data/size handshake as the existing cache-to-AXI ports.
- One request is in flight at a time. The winning request is latched and forwarded; the response is routed back only to the granted channel.
- Arbitration is selectable: fixed priority or round-robin.

---
 rtl/ysyx_22040759_mem_arbiter.sv | 119 +++++++++++
 tb/tb_ysyx_22040759_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040759_mem_arbiter.sv
// N-channel memory arbiter: merges upstream requesters onto one downstream
// port, one transfer in flight, fixed-priority or round-robin selection.
// Ports: clock/reset; up_valid/up_req/up_addr/up_data_write/up_size in,
// up_ready/up_data_read out; mem_valid/mem_req/mem_addr/mem_data_write/
// mem_size out, mem_ready/mem_data_read in; grant_id debug out.
module ysyx_22040759_mem_arbiter #(
  parameter int NCH      = 2,
  parameter int AW       = 32,
  parameter int DW       = 64,
  parameter int ARB_MODE = 1,
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH-1:0]    up_valid,
  input  logic [NCH-1:0]    up_req,
  input  logic [NCH*AW-1:0] up_addr,
  input  logic [NCH*DW-1:0] up_data_write,
  input  logic [NCH*3-1:0]  up_size,
  output logic [NCH-1:0]    up_ready,
  output logic [DW-1:0]     up_data_read,
  output logic              mem_valid,
  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_data_write,
  output logic [2:0]        mem_size,
  input  logic              mem_ready,
  input  logic [DW-1:0]     mem_data_read,
  output logic [GW-1:0]     grant_id
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   rr_nx;
  logic [GW-1:0]   win;
  logic [GW-1:0]   idx_g;
  logic            found;
  logic            grant_en;
  logic            done;
  logic [DW-1:0]   rdata_q;
  int              idx;

  // Search order starts at rr_ptr in round-robin mode, at 0 otherwise.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    idx_g = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ARB_MODE == 0) begin
        idx = k;
      end else begin
        idx = int'(rr_ptr) + k;
        if (idx >= NCH) idx = idx - NCH;
      end
      idx_g = GW'(idx);
      if (!found && up_valid[idx_g]) begin
        found = 1'b1;
        win   = idx_g;
      end
    end
  end

  always_comb begin
    rr_nx = '0;
    if (win != GW'(NCH - 1)) rr_nx = win + GW'(1);
  end

  assign grant_en  = (state_q == IDLE) && found;
  assign done      = (state_q == BUSY) && mem_ready;
  assign mem_valid = (state_q == BUSY);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (found) state_d = BUSY;
      BUSY: if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    up_ready = '0;
    if (done) up_ready[grant_id] = 1'b1;
  end

  assign up_data_read = done ? mem_data_read : rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      mem_data_write <= '0;
      mem_size       <= '0;
      grant_id       <= '0;
      rr_ptr         <= '0;
      rdata_q        <= '0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        mem_req        <= up_req[win];
        mem_addr       <= up_addr[int'(win)*AW +: AW];
        mem_data_write <= up_data_write[int'(win)*DW +: DW];
        mem_size       <= up_size[int'(win)*3 +: 3];
        grant_id       <= win;
        if (ARB_MODE != 0) rr_ptr <= rr_nx;
      end
      if (done) rdata_q <= mem_data_read;
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// Directed bench for ysyx_22040759_mem_arbiter: a 2-channel fixed-priority
// instance and a 4-channel round-robin instance share clock/reset/mem side.
module tb_ysyx_22040759_mem_arbiter;

  logic         clock;
  logic         reset;
  logic         mem_ready;
  logic [63:0]  mem_data_read;

  logic [1:0]   fp_valid, fp_req;
  logic [63:0]  fp_addr;
  logic [127:0] fp_wdata;
  logic [5:0]   fp_size;
  logic [1:0]   fp_up_ready;
  logic [63:0]  fp_rdata;
  logic         fp_mvalid, fp_mreq;
  logic [31:0]  fp_maddr;
  logic [63:0]  fp_mwdata;
  logic [2:0]   fp_msize;
  logic [0:0]   fp_gid;

  logic [3:0]   rr_valid, rr_req;
  logic [127:0] rr_addr;
  logic [255:0] rr_wdata;
  logic [11:0]  rr_size;
  logic [3:0]   rr_up_ready;
  logic [63:0]  rr_rdata;
  logic         rr_mvalid, rr_mreq;
  logic [31:0]  rr_maddr;
  logic [63:0]  rr_mwdata;
  logic [2:0]   rr_msize;
  logic [1:0]   rr_gid;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  ysyx_22040759_mem_arbiter #(.NCH(2), .AW(32), .DW(64), .ARB_MODE(0)) dut_fp (
    .clock(clock), .reset(reset),
    .up_valid(fp_valid), .up_req(fp_req), .up_addr(fp_addr),
    .up_data_write(fp_wdata), .up_size(fp_size),
    .up_ready(fp_up_ready), .up_data_read(fp_rdata),
    .mem_valid(fp_mvalid), .mem_req(fp_mreq), .mem_addr(fp_maddr),
    .mem_data_write(fp_mwdata), .mem_size(fp_msize),
    .mem_ready(mem_ready), .mem_data_read(mem_data_read),
    .grant_id(fp_gid)
  );

  ysyx_22040759_mem_arbiter #(.NCH(4), .AW(32), .DW(64), .ARB_MODE(1)) dut_rr (
    .clock(clock), .reset(reset),
    .up_valid(rr_valid), .up_req(rr_req), .up_addr(rr_addr),
    .up_data_write(rr_wdata), .up_size(rr_size),
    .up_ready(rr_up_ready), .up_data_read(rr_rdata),
    .mem_valid(rr_mvalid), .mem_req(rr_mreq), .mem_addr(rr_maddr),
    .mem_data_write(rr_mwdata), .mem_size(rr_msize),
    .mem_ready(mem_ready), .mem_data_read(mem_data_read),
    .grant_id(rr_gid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    mem_data_read = '0;
    fp_valid = '0; fp_req = '0; fp_addr = '0; fp_wdata = '0; fp_size = '0;
    rr_valid = '0; rr_req = '0; rr_addr = '0; rr_wdata = '0; rr_size = '0;
    repeat (3) @(negedge clock);
    tot_cnt++;
    if (fp_mvalid !== 1'b0) $display("FAIL reset_fp_mvalid got %h exp 0", fp_mvalid);
    else pass_cnt++;
    tot_cnt++;
    if (fp_up_ready !== 2'b00) $display("FAIL reset_fp_up_ready got %h exp 0", fp_up_ready);
    else pass_cnt++;
    tot_cnt++;
    if ({fp_mreq, fp_maddr, fp_mwdata, fp_msize, fp_gid, fp_rdata} !== '0)
      $display("FAIL reset_fp_regs got %h exp 0", {fp_mreq, fp_maddr, fp_msize, fp_gid});
    else pass_cnt++;
    tot_cnt++;
    if (rr_mvalid !== 1'b0 || rr_gid !== 2'd0)
      $display("FAIL reset_rr_out got %h/%h exp 0/0", rr_mvalid, rr_gid);
    else pass_cnt++;
    tot_cnt++;
    if (dut_rr.rr_ptr !== 2'd0) $display("FAIL reset_rr_ptr got %0d exp 0", dut_rr.rr_ptr);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    @(negedge clock);
    fp_valid = 2'b01;
    fp_req = 2'b00;
    fp_addr[31:0] = 32'h8000_0000;
    fp_size[2:0] = 3'd3;
    @(negedge clock);
    tot_cnt++;
    if (fp_mvalid !== 1'b1 || fp_maddr !== 32'h8000_0000)
      $display("FAIL read_issue got v=%h a=%h exp v=1 a=80000000", fp_mvalid, fp_maddr);
    else pass_cnt++;
    tot_cnt++;
    if (fp_mreq !== 1'b0 || fp_msize !== 3'd3)
      $display("FAIL read_fields got req=%h sz=%0d exp req=0 sz=3", fp_mreq, fp_msize);
    else pass_cnt++;
    repeat (3) @(negedge clock);
    mem_ready = 1'b1;
    mem_data_read = 64'h1122_3344_5566_7788;
    #1;
    tot_cnt++;
    if (fp_up_ready !== 2'b01) $display("FAIL read_up_ready got %b exp 01", fp_up_ready);
    else pass_cnt++;
    tot_cnt++;
    if (fp_rdata !== 64'h1122_3344_5566_7788)
      $display("FAIL read_data got %h exp 1122334455667788", fp_rdata);
    else pass_cnt++;
    @(negedge clock);
    mem_ready = 1'b0;
    mem_data_read = 64'h0;
    fp_valid = 2'b00;
    #1;
    tot_cnt++;
    if (fp_mvalid !== 1'b0 || fp_up_ready !== 2'b00)
      $display("FAIL read_done got v=%h r=%b exp v=0 r=00", fp_mvalid, fp_up_ready);
    else pass_cnt++;
    tot_cnt++;
    if (fp_rdata !== 64'h1122_3344_5566_7788)
      $display("FAIL read_hold got %h exp 1122334455667788", fp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_write();
    @(negedge clock);
    fp_valid = 2'b10;
    fp_req = 2'b10;
    fp_addr[63:32] = 32'h8000_1008;
    fp_wdata[127:64] = 64'hDEAD_BEEF;
    fp_size[5:3] = 3'd2;
    @(negedge clock);
    tot_cnt++;
    if (fp_mreq !== 1'b1 || fp_mwdata !== 64'hDEAD_BEEF)
      $display("FAIL write_fields got req=%h d=%h exp req=1 d=deadbeef", fp_mreq, fp_mwdata);
    else pass_cnt++;
    tot_cnt++;
    if (fp_maddr !== 32'h8000_1008 || fp_msize !== 3'd2)
      $display("FAIL write_addr got a=%h sz=%0d exp a=80001008 sz=2", fp_maddr, fp_msize);
    else pass_cnt++;
    mem_ready = 1'b1;
    mem_data_read = 64'h0000_0000_CAFE_F00D;
    #1;
    tot_cnt++;
    if (fp_up_ready !== 2'b10 || fp_gid !== 1'b1)
      $display("FAIL write_route got r=%b g=%0d exp r=10 g=1", fp_up_ready, fp_gid);
    else pass_cnt++;
    @(negedge clock);
    mem_ready = 1'b0;
    fp_valid = 2'b00;
    fp_req = 2'b00;
  endtask

  task automatic test_fixed_priority();
    @(negedge clock);
    fp_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tot_cnt++;
      if (fp_mvalid !== 1'b1 || fp_gid !== 1'b0)
        $display("FAIL fixed_grant%0d got v=%h g=%0d exp v=1 g=0", i, fp_mvalid, fp_gid);
      else pass_cnt++;
      mem_ready = 1'b1;
      #1;
      tot_cnt++;
      if (fp_up_ready !== 2'b01)
        $display("FAIL fixed_ready%0d got %b exp 01", i, fp_up_ready);
      else pass_cnt++;
      @(negedge clock);
      mem_ready = 1'b0;
      if (i == 2) fp_valid = 2'b10;
      #1;
      tot_cnt++;
      if (fp_mvalid !== 1'b0)
        $display("FAIL fixed_dead%0d got %h exp 0", i, fp_mvalid);
      else pass_cnt++;
    end
    @(negedge clock);
    tot_cnt++;
    if (fp_gid !== 1'b1 || fp_maddr !== 32'h8000_1008)
      $display("FAIL fixed_ch1 got g=%0d a=%h exp g=1 a=80001008", fp_gid, fp_maddr);
    else pass_cnt++;
    mem_ready = 1'b1;
    #1;
    tot_cnt++;
    if (fp_up_ready !== 2'b10) $display("FAIL fixed_ch1_ready got %b exp 10", fp_up_ready);
    else pass_cnt++;
    @(negedge clock);
    mem_ready = 1'b0;
    fp_valid = 2'b00;
  endtask

  task automatic test_round_robin();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    logic [1:0] g;
    logic [1:0] p;
    logic [3:0] r;
    @(negedge clock);
    reset = 1'b1;
    rr_valid = 4'hF;
    for (int c = 0; c < 4; c++) rr_addr[c*32 +: 32] = 32'h1000 * c;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      g = 2'(exp_g[i]);
      p = 2'((exp_g[i] + 1) % 4);
      r = 4'b0001 << exp_g[i];
      tot_cnt++;
      if (rr_mvalid !== 1'b1 || rr_gid !== g || rr_maddr !== 32'h1000 * exp_g[i])
        $display("FAIL rr_grant%0d got v=%h g=%0d a=%h exp g=%0d", i, rr_mvalid, rr_gid, rr_maddr, g);
      else pass_cnt++;
      tot_cnt++;
      if (dut_rr.rr_ptr !== p)
        $display("FAIL rr_ptr%0d got %0d exp %0d", i, dut_rr.rr_ptr, p);
      else pass_cnt++;
      mem_ready = 1'b1;
      #1;
      tot_cnt++;
      if (rr_up_ready !== r)
        $display("FAIL rr_ready%0d got %b exp %b", i, rr_up_ready, r);
      else pass_cnt++;
      @(negedge clock);
      mem_ready = 1'b0;
      if (i == 4) rr_valid = 4'h0;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    rr_valid = 4'b0100;
    @(negedge clock);
    tot_cnt++;
    if (rr_mvalid !== 1'b1 || rr_gid !== 2'd2)
      $display("FAIL mid_busy got v=%h g=%0d exp v=1 g=2", rr_mvalid, rr_gid);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clock);
    tot_cnt++;
    if (rr_mvalid !== 1'b0 || rr_up_ready !== 4'b0000)
      $display("FAIL mid_abort got v=%h r=%b exp v=0 r=0000", rr_mvalid, rr_up_ready);
    else pass_cnt++;
    tot_cnt++;
    if (dut_rr.rr_ptr !== 2'd0 || rr_gid !== 2'd0)
      $display("FAIL mid_ptr got p=%0d g=%0d exp 0/0", dut_rr.rr_ptr, rr_gid);
    else pass_cnt++;
    rr_valid = 4'b0000;
    reset = 1'b0;
    mem_ready = 1'b1;
    mem_data_read = 64'h5555_AAAA_5555_AAAA;
    #1;
    tot_cnt++;
    if (rr_up_ready !== 4'b0000 || fp_up_ready !== 2'b00)
      $display("FAIL mid_late_ready got %b/%b exp 0000/00", rr_up_ready, fp_up_ready);
    else pass_cnt++;
    @(negedge clock);
    mem_ready = 1'b0;
    #1;
    tot_cnt++;
    if (rr_mvalid !== 1'b0) $display("FAIL mid_idle got %h exp 0", rr_mvalid);
    else pass_cnt++;
  endtask

  task automatic test_spurious();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      mem_ready = 1'b1;
      mem_data_read = 64'h0BAD_0BAD_0BAD_0BAD;
      #1;
      tot_cnt++;
      if (fp_up_ready !== 2'b00 || fp_mvalid !== 1'b0)
        $display("FAIL spur%0d got r=%b v=%h exp r=00 v=0", i, fp_up_ready, fp_mvalid);
      else pass_cnt++;
    end
    tot_cnt++;
    if (fp_rdata !== 64'h0) $display("FAIL spur_data got %h exp 0", fp_rdata);
    else pass_cnt++;
    @(negedge clock);
    mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_fixed_priority();
    test_round_robin();
    test_reset_mid();
    test_spurious();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
